// File: rtl/multdiv_seq_if.sv
// Operand/control/result bundle between the execute stage and the iterative
// multiply/divide unit. The pipeline side is the master; the unit is the slave.
interface multdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 shift-add) / divide (restoring) unit, WIDTH iterations.
// Optional MULTDIV_DIVZERO_FAST_EN: a divide by zero completes one edge after its start.
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    multdiv_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude as an unsigned value; the most-negative input maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        mag = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 neg_q, neg_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 exc_q, exc_d;
    logic                 rdy_q, rdy_d;

    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH:0]     mstep_s;
    logic [WIDTH:0]       sh_s;
    logic                 ge_s;
    logic [WIDTH:0]       rem_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s;
    logic                 fast_s;

    // Multiply step: acc = {partial high, remaining multiplier bits}.
    assign sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mstep_s = acc_q[0] ? {sum_s, acc_q[WIDTH-1:0]} : {1'b0, acc_q};
    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
    assign sh_s    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign ge_s    = (sh_s >= {1'b0, opb_q});
    assign rem_s   = ge_s ? (sh_s - {1'b0, opb_q}) : sh_s;
    assign prod_s  = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    assign quo_s   = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
`ifdef MULTDIV_DIVZERO_FAST_EN
    assign fast_s  = div0_q;
`else
    assign fast_s  = 1'b0;
`endif

    // Next-state, datapath iteration and result formation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            MULT: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d  = DONE;
                    result_d = prod_s[WIDTH-1:0];
                    exc_d    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
                    rdy_d    = 1'b1;
                end else begin
                    acc_d = mstep_s[2*WIDTH:1];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV: begin
                if ((cnt_q == CNT_W'(WIDTH)) || fast_s) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    if (div0_q) begin
                        result_d = {WIDTH{1'b0}};
                        exc_d    = 1'b1;
                    end else begin
                        result_d = quo_s;
                        // Only -2^(WIDTH-1) / -1 yields a positive quotient with the top bit set.
                        exc_d    = ~neg_q & acc_q[WIDTH-1];
                    end
                end else begin
                    acc_d = {rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], ge_s};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start in any state aborts the current operation without touching held results.
        if (bus.ctrl_MULT) begin
            state_d  = MULT;
            cnt_d    = {CNT_W{1'b0}};
            acc_d    = {{WIDTH{1'b0}}, mag(bus.data_operandB)};
            opb_d    = mag(bus.data_operandA);
            neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            div0_d   = 1'b0;
            result_d = result_q;
            exc_d    = exc_q;
            rdy_d    = 1'b0;
        end else if (bus.ctrl_DIV) begin
            state_d  = DIV;
            cnt_d    = {CNT_W{1'b0}};
            acc_d    = {{WIDTH{1'b0}}, mag(bus.data_operandA)};
            opb_d    = mag(bus.data_operandB);
            neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            div0_d   = (bus.data_operandB == {WIDTH{1'b0}});
            result_d = result_q;
            exc_d    = exc_q;
            rdy_d    = 1'b0;
        end else begin
            rdy_d = rdy_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq: arithmetic, latency, restart, reset.
module tb_multdiv_seq;
    localparam int WIDTH = 32;
`ifdef MULTDIV_DIVZERO_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    int   lat;
    int   pulses;

    multdiv_seq_if #(.WIDTH(WIDTH)) bus ();

    multdiv_seq #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start on the negedge so edge E samples it; scramble operands after E.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Edges after E until ready is seen; 0 means the bound expired.
    task automatic wait_ready(output int l);
        l = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic m, input logic d,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
        start_op(m, d, a, b);
        wait_ready(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus.data_result, exp_res);
        check({tag, "_exc"}, {31'd0, bus.data_exception}, {31'd0, exp_exc});
        @(posedge clock);
        #1;
        check({tag, "_rdy_width"}, {31'd0, bus.data_resultRDY}, 32'd0);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        #3;
        check("rst_res", bus.data_result, 32'd0);
        check("rst_exc", {31'd0, bus.data_exception}, 32'd0);
        check("rst_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        #9;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("idle_rdy", {31'd0, bus.data_resultRDY}, 32'd0);

        run_check("mul_7_m6", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0, 33);

        // Results hold across a new start until the next completion.
        start_op(1'b1, 1'b0, 32'h00010000, 32'h00010000);
        repeat (5) @(posedge clock);
        #1;
        check("hold_res", bus.data_result, 32'hFFFFFFD6);
        wait_ready(lat);
        check("mul_ovf_lat", 32'(lat), 32'd28);
        check("mul_ovf_res", bus.data_result, 32'h00000000);
        check("mul_ovf_exc", {31'd0, bus.data_exception}, 32'd1);

        run_check("mul_min_1", 1'b1, 1'b0, 32'h80000000, 32'd1, 32'h80000000, 1'b0, 33);
        run_check("mul_m1_m1", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 33);
        run_check("div_m7_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33);
        run_check("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 33);
        run_check("div_ovf", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33);
        run_check("div_min_2", 1'b0, 1'b1, 32'h80000000, 32'd2, 32'hC0000000, 1'b0, 33);
        run_check("div_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, DIV0_LAT);

        // Restart: DIV at E, MULT at E+10; single ready 33 edges after the MULT.
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (9) @(posedge clock);
        run_check("restart", 1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, 33);

        run_check("both_start", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, 33);

        // Asynchronous reset between E+15 and E+16.
        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (15) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_res", bus.data_result, 32'd0);
        check("arst_exc", {31'd0, bus.data_exception}, 32'd0);
        check("arst_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        #2;
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) pulses++;
        end
        check("arst_no_rdy", 32'(pulses), 32'd0);
        run_check("after_rst", 1'b1, 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Iterative signed 32-bit multiply/divide unit. It is the multicycle complement to the single-cycle ALU.
- It sits beside the ALU in the processor execute stage. The pipeline stalls on it until a ready pulse.
- It uses a start-pulse / ready-pulse handshake. One operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- data_operandA  input  WIDTH  multiplicand / dividend, two's complement
- data_operandB  input  WIDTH  multiplier / divisor, two's complement
- ctrl_MULT  input  1  single-cycle start pulse for multiply
- ctrl_DIV  input  1  single-cycle start pulse for divide
- data_result  output  WIDTH  product low word or quotient
- data_exception  output  1  overflow or divide-by-zero flag for data_result
- data_resultRDY  output  1  one-cycle pulse; data_result and data_exception are valid

Behaviour:
- Interface: one clock, reset is asynchronous and active-low (ports clock, reset_n).
- Reset (reset_n=0, asynchronous):
  - state returns to IDLE; iteration counter is cleared.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - After release, nothing happens until a start pulse.
- FSM states: IDLE, MULT, DIV, DONE.
- Start:
  - A start pulse is sampled at rising edge E, in any state.
  - Operands are captured at E. Operand changes after E are ignored.
  - The state moves to MULT or DIV with counter=0.
- Both starts in the same cycle: ctrl_MULT wins and ctrl_DIV is dropped.
- Restart: a start pulse during MULT, DIV or DONE aborts the current operation with no ready pulse and restarts from the new operands.
- MULT:
  - Radix-2 shift-add on magnitudes; the sign is applied at the end.
  - One iteration per edge, WIDTH iterations.
  - Edges E+1..E+32 iterate. Edge E+33 enters DONE.
- DIV:
  - Restoring division on magnitudes, one quotient bit per edge.
  - Same timing as MULT.
- DONE:
  - At edge E+33, data_result and data_exception are registered.
  - data_resultRDY=1 for exactly the cycle between E+33 and E+34.
  - Edge E+34 returns to IDLE.
- Hold rule: data_result and data_exception hold their value until the next DONE or reset. They do not clear on a new start.
- Multiply arithmetic:
  - data_result = low WIDTH bits of the signed 2*WIDTH product.
  - data_exception=1 iff the high WIDTH bits are not all equal to bit WIDTH-1 of the product.
- Divide arithmetic:
  - Quotient is truncated toward zero; the remainder is discarded.
  - The quotient sign is the XOR of the operand signs. A zero quotient is never negative.
- Divide by zero: data_result=0, data_exception=1.
- Divide overflow, -2^31 / -1: data_result=0x80000000, data_exception=1.
- Most-negative operand (0x80000000): its magnitude must be handled as an unsigned 2^31, with no overflow in the magnitude path.
- data_resultRDY is never high outside DONE. It is never asserted twice for one start.

Optional Feature:
- Macro: MULTDIV_DIVZERO_FAST_EN.
- Defined:
  - A ctrl_DIV with data_operandB==0 at edge E goes directly to DONE at E+1.
  - data_result=0, data_exception=1, ready high between E+1 and E+2.
  - All other operations are unchanged.
- Undefined:
  - Divide-by-zero runs the full 33-edge latency.
  - Same result/exception values; ready between E+33 and E+34.

Test Plan:
- Multiply sign handling: ctrl_MULT, A=7, B=-6 at E -> ready in cycle E+33..E+34, result 0xFFFFFFD6, exception 0; ready low in all other cycles.
- Multiply overflow: ctrl_MULT, A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. Also A=0x80000000, B=1 -> result 0x80000000, exception 0.
- Divide truncation and overflow: ctrl_DIV, A=-7, B=2 -> result 0xFFFFFFFD, exception 0. Also A=0x80000000, B=-1 -> result 0x80000000, exception 1.
- Divide by zero: ctrl_DIV, A=5, B=0 -> result 0, exception 1. Ready at E+33 without the macro; ready at E+1 with MULTDIV_DIVZERO_FAST_EN defined.
- Restart and priority:
  - ctrl_DIV, A=100, B=7 at E, then ctrl_MULT, A=3, B=4 at E+10 -> a single ready pulse at E+43 with result 12; no pulse at E+33.
  - ctrl_MULT and ctrl_DIV together with A=6, B=3 -> result 18.
- Reset mid-operation: ctrl_MULT at E, reset_n low asynchronously between E+15 and E+16 (off-edge) -> outputs 0 immediately. No ready pulse afterwards until a new start; a new start gives a correct result 33 edges later.
